// File: rtl/flipflop_bank_arbiter_if.sv
// Request/grant bundle between the producers and the shared-register arbiter.
interface flipflop_bank_arbiter_if #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
);
  localparam int unsigned IW = $clog2(N);

  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   lock;
  logic [N-1:0]   gnt;
  logic [IW-1:0]  owner;
  logic [W-1:0]   q;
  logic           q_valid;

  modport master (output req, wdata, lock, input gnt, owner, q, q_valid);
  modport slave  (input req, wdata, lock, output gnt, owner, q, q_valid);
endinterface

// File: rtl/flipflop_bank_arbiter.sv
// Round-robin arbiter owning one shared W-bit register written by N requesters.
// Optional hold-grant mode enabled by defining FF_ARB_LOCK_EN.
module flipflop_bank_arbiter #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  flipflop_bank_arbiter_if.slave   bus
);
  localparam int unsigned IW = $clog2(N);

`ifdef FF_ARB_LOCK_EN
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, LOCK = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1} state_t;
`endif

  state_t         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IW-1:0]  owner_q, owner_d;
  logic [IW-1:0]  ptr_q, ptr_d;
  logic [W-1:0]   q_q, q_d;
  logic           q_valid_q, q_valid_d;

  logic [N-1:0]   eff_req;
  logic           found;
  logic [IW-1:0]  win;
  logic [W-1:0]   win_data;
  int unsigned    idx;

`ifdef FF_ARB_LOCK_EN
  logic           lock_hold;
  logic [W-1:0]   lock_data;
  assign lock_hold = bus.req[owner_q] & bus.lock[owner_q];
  assign lock_data = W'(bus.wdata >> (32'(owner_q) * W));
`else
  logic unused_lock;
  assign unused_lock = ^bus.lock;
`endif

  // Scan masked requests starting at ptr; only the winner's slice is ever selected.
  always_comb begin
    eff_req  = bus.req & ~gnt_q;
    found    = 1'b0;
    win      = '0;
    win_data = '0;
    idx      = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= N) idx = idx - N;
      if (!found && eff_req[IW'(idx)]) begin
        found    = 1'b1;
        win      = IW'(idx);
        win_data = W'(bus.wdata >> (idx * W));
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
`ifdef FF_ARB_LOCK_EN
      LOCK: state_d = lock_hold ? LOCK : IDLE;
`endif
      default: begin
        if (found) begin
          state_d = GRANT;
`ifdef FF_ARB_LOCK_EN
          if (bus.lock[win]) state_d = LOCK;
`endif
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_comb begin
    gnt_d     = '0;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    q_d       = q_q;
    q_valid_d = q_valid_q;
    case (state_q)
`ifdef FF_ARB_LOCK_EN
      LOCK: begin
        if (lock_hold) begin
          gnt_d = gnt_q;
          q_d   = lock_data;
        end
      end
`endif
      default: begin
        if (found) begin
          gnt_d     = N'(1) << win;
          q_d       = win_data;
          owner_d   = win;
          q_valid_d = 1'b1;
          ptr_d     = (win == IW'(N - 1)) ? '0 : win + IW'(1);
        end
      end
    endcase
  end

  assign bus.gnt     = gnt_q;
  assign bus.owner   = owner_q;
  assign bus.q       = q_q;
  assign bus.q_valid = q_valid_q;
endmodule

// File: tb/tb_flipflop_bank_arbiter.sv
// Randomized scoreboard bench for flipflop_bank_arbiter against a rule-level model.
module tb_flipflop_bank_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned IW = $clog2(N);

  typedef struct packed {
    logic [N-1:0]  gnt;
    logic [IW-1:0] owner;
    logic [W-1:0]  q;
    logic          qv;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;

  flipflop_bank_arbiter_if #(.N(N), .W(W)) bus ();
  flipflop_bank_arbiter #(.N(N), .W(W)) dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state: what the shared register system should look like.
  int           m_ptr    = 0;
  int           m_owner  = 0;
  logic [N-1:0] m_gnt    = '0;
  logic [W-1:0] m_q      = '0;
  bit           m_qv     = 1'b0;
  bit           m_locked = 1'b0;

  function automatic logic [W-1:0] slice(input logic [N*W-1:0] d, input int k);
    return d[k*W +: W];
  endfunction

  function automatic logic [N*W-1:0] ramp(input int base);
    logic [N*W-1:0] d;
    for (int k = 0; k < N; k++) d[k*W +: W] = W'(base + k);
    return d;
  endfunction

  task automatic model_step(input logic rst, input logic [N-1:0] r, input logic [N-1:0] l,
                            input logic [N*W-1:0] d);
    logic [N-1:0] eff;
    int kk;
    exp_t e;
    if (!rst) begin
      m_ptr = 0; m_owner = 0; m_gnt = '0; m_q = '0; m_qv = 1'b0; m_locked = 1'b0;
    end else if (m_locked) begin
      if (r[m_owner] && l[m_owner]) m_q = slice(d, m_owner);
      else begin
        m_locked = 1'b0;
        m_gnt    = '0;
      end
    end else begin
      eff = r & ~m_gnt;
      kk  = -1;
      for (int o = 0; o < N; o++)
        if (kk < 0 && eff[(m_ptr + o) % N]) kk = (m_ptr + o) % N;
      if (kk >= 0) begin
        m_gnt   = '0;
        m_gnt[kk] = 1'b1;
        m_q     = slice(d, kk);
        m_owner = kk;
        m_qv    = 1'b1;
        m_ptr   = (kk + 1) % N;
`ifdef FF_ARB_LOCK_EN
        m_locked = l[kk];
`endif
      end else begin
        m_gnt = '0;
      end
    end
    e.gnt = m_gnt; e.owner = IW'(m_owner); e.q = m_q; e.qv = m_qv;
    sb.push_back(e);
  endtask

  task automatic drive(input logic rst, input logic [N-1:0] r, input logic [N-1:0] l,
                       input logic [N*W-1:0] d);
    @(negedge clock);
    reset     = rst;
    bus.req   = r;
    bus.lock  = l;
    bus.wdata = d;
    model_step(rst, r, l, d);
  endtask

  // Monitor: one expected record per clock, compared just after the edge.
  initial begin
    exp_t e;
    int cyc = 0;
    forever begin
      @(posedge clock);
      #1;
      cyc++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if (bus.gnt !== e.gnt || bus.owner !== e.owner || bus.q !== e.q || bus.q_valid !== e.qv) begin
          n_errors++;
          $display("FAIL outputs cyc=%0d got gnt=%b owner=%0d q=%h qv=%b exp gnt=%b owner=%0d q=%h qv=%b",
                   cyc, bus.gnt, bus.owner, bus.q, bus.q_valid, e.gnt, e.owner, e.q, e.qv);
        end
        n_checks++;
        if (!$onehot0(bus.gnt)) begin
          n_errors++;
          $display("FAIL gnt_onehot cyc=%0d got gnt=%b exp at most one bit", cyc, bus.gnt);
        end
      end
    end
  end

  initial begin
    logic [N-1:0] r, l;
    logic [N*W-1:0] d;
    bus.req = '0; bus.lock = '0; bus.wdata = '0;

    repeat (3) drive(1'b0, 4'hF, 4'h0, ramp(8'h10));
    drive(1'b1, 4'b0100, 4'h0, 32'h00A5_0000);
    repeat (2) drive(1'b1, 4'h0, 4'h0, 32'h0);

    repeat (8) drive(1'b1, 4'hF, 4'h0, ramp(8'h10));
    drive(1'b0, 4'h0, 4'h0, 32'h0);
    repeat (6) drive(1'b1, 4'b0010, 4'h0, ramp(8'h20));

    drive(1'b1, 4'b0100, 4'h0, ramp(8'h30));
    drive(1'b1, 4'h0, 4'h0, 32'h0);
    repeat (4) drive(1'b1, 4'b1001, 4'b1000, 32'hC3_00_00_5A);
    repeat (4) drive(1'b1, 4'b0001, 4'h0, 32'h00_00_00_77);

    repeat (4) drive(1'b1, 4'h0, 4'h0, 32'h0);
    repeat (2) drive(1'b1, 4'b1000, 4'b1000, ramp(8'h50));
    drive(1'b0, 4'hF, 4'hF, ramp(8'h60));
    repeat (4) drive(1'b1, 4'hF, 4'h0, ramp(8'h40));

    for (int c = 0; c < 600; c++) begin
      r = N'($urandom);
      l = N'($urandom) & N'($urandom | $urandom);
      d = (N*W)'($urandom);
      drive(($urandom_range(0, 59) != 0), r, l, d);
    end

    repeat (3) @(negedge clock);
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL drain got %0d pending exp 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
